binary_decoder: RTL and testbench
=================================

BINARY_DECODER -- requirements
Module: binary_decoder

Interface
REQ-001 Parameter OUTPUTS, default 4: number of one-hot output lines; SHALL be >= 2.
REQ-002 Parameter OUTPUTS_WIDTH, default 2: width of select; SHALL be >= ceil(log2(OUTPUTS)).
REQ-003 Port clk  input  1  rising-edge clock; one clock domain only.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port select  input  OUTPUTS_WIDTH  binary index of the line to assert, unsigned.
REQ-006 Port out  output  OUTPUTS  one-hot decoded output, registered.

Function
REQ-007 On each rising clk edge with rst low, out SHALL load the one-hot code of select: bit[select]=1, all other bits 0.
REQ-008 Latency SHALL be exactly 1 clk cycle: select sampled at edge N appears on out after edge N, held until edge N+1.
REQ-009 out SHALL have at most one bit set at all times, never more (no glitch-level multi-hot on the registered output).
REQ-010 If select >= OUTPUTS (possible when OUTPUTS is not a power of two, or OUTPUTS_WIDTH oversized), out SHALL load all zeros.
REQ-011 If select is stable, out SHALL remain constant; no internal state beyond the out register.
REQ-012 select containing X/Z in simulation SHALL not be relied upon; after it resolves, REQ-007 applies from the next edge.
REQ-013 The select-to-index comparison SHALL be unsigned and full OUTPUTS_WIDTH wide; no truncation of select to ceil(log2(OUTPUTS)) bits.
REQ-014 The design SHALL fail elaboration (error message) if OUTPUTS < 2 or 2**OUTPUTS_WIDTH < OUTPUTS.

Reset
REQ-015 While rst is high at a rising clk edge, out SHALL load all zeros, regardless of select.
REQ-016 Reset asserted mid-operation SHALL clear out at the next edge; first decoded value appears on the edge after rst deasserts.
REQ-017 No asynchronous reset path SHALL exist; rst has no effect between clock edges.

Structure
REQ-018 No shared package SHALL be required; OUTPUTS and OUTPUTS_WIDTH are module parameters, any derived constants local parameters.
REQ-019 The block SHALL be a single module with no sub-modules: combinational decode feeding one OUTPUTS-bit register.

Verification
REQ-020 Reset: rst=1 for 2 cycles with select=3 -> out=4'b0000 throughout; rst=0 -> out=4'b1000 one cycle later.
REQ-021 Sweep: select=0,1,2,3, each held 1000 ns (clk period 10 ns) -> out=4'b0001,0010,0100,1000, each change one cycle after select change.
REQ-022 Latency: select changes 1->2 just after edge N -> out stays 4'b0010 until edge N+1, then 4'b0100.
REQ-023 Out-of-range: OUTPUTS=5, OUTPUTS_WIDTH=3, select=5,6,7 -> out=5'b00000; select=4 -> 5'b10000.
REQ-024 Mid-run reset: select=2, out=4'b0100, rst pulsed high one cycle -> out=4'b0000 for that cycle, 4'b0100 on following edge.
REQ-025 Invariant check every cycle across all tests: popcount(out) <= 1.

Source files
------------

// File: rtl/binary_decoder.sv
// Registered binary-to-one-hot decoder: out loads the one-hot code of select
// each clock. Indices at or beyond OUTPUTS load all zeros.
module binary_decoder #(
  parameter int OUTPUTS       = 4,
  parameter int OUTPUTS_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [OUTPUTS_WIDTH-1:0] select,
  output logic [OUTPUTS-1:0]       out
);

  localparam longint SELECT_RANGE = longint'(1) << OUTPUTS_WIDTH;

  generate
    if (OUTPUTS < 2) begin : g_err_outputs
      $error("binary_decoder: OUTPUTS must be >= 2");
    end
    if (SELECT_RANGE < longint'(OUTPUTS)) begin : g_err_width
      $error("binary_decoder: OUTPUTS_WIDTH too narrow to address all OUTPUTS lines");
    end
  endgenerate

  logic [OUTPUTS-1:0] w_decoded;
  logic [OUTPUTS-1:0] r_out;

  // Full-width compare: an out-of-range select matches no line and yields zero.
  always_comb begin
    w_decoded = '0;
    for (int i = 0; i < OUTPUTS; i++) begin
      if (select == OUTPUTS_WIDTH'(i)) begin
        w_decoded[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_decoded;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_binary_decoder.sv
// Bench for binary_decoder: a default 4-output instance and a 5-output instance
// with a 3-bit select to cover out-of-range indices.
module tb_binary_decoder;

  logic       clk = 1'b0;
  logic       rst_a;
  logic [1:0] sel_a;
  logic [3:0] out_a;
  logic       rst_b;
  logic [2:0] sel_b;
  logic [4:0] out_b;

  int checks = 0;
  int errors = 0;
  bit inv_en = 1'b0;

  always #5 clk = ~clk;

  binary_decoder #(.OUTPUTS(4), .OUTPUTS_WIDTH(2)) u_dut_a (
    .clk    (clk),
    .rst    (rst_a),
    .select (sel_a),
    .out    (out_a)
  );

  binary_decoder #(.OUTPUTS(5), .OUTPUTS_WIDTH(3)) u_dut_b (
    .clk    (clk),
    .rst    (rst_b),
    .select (sel_b),
    .out    (out_b)
  );

  typedef struct {
    logic [1:0] sel;
    logic [3:0] exp;
  } vec4_t;

  typedef struct {
    logic [2:0] sel;
    logic [4:0] exp;
  } vec5_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One-hot invariant on both instances, sampled mid-cycle.
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if ($countones(out_a) > 1 || $countones(out_b) > 1 || $isunknown(out_a) || $isunknown(out_b)) begin
        errors++;
        $display("FAIL onehot_invariant: out_a %b out_b %b", out_a, out_b);
      end
    end
  end

  initial begin
    vec4_t      sweep[4];
    vec5_t      range5[8];
    logic [3:0] prev;

    sweep[0] = '{sel: 2'd0, exp: 4'b0001};
    sweep[1] = '{sel: 2'd1, exp: 4'b0010};
    sweep[2] = '{sel: 2'd2, exp: 4'b0100};
    sweep[3] = '{sel: 2'd3, exp: 4'b1000};

    range5[0] = '{sel: 3'd0, exp: 5'b00001};
    range5[1] = '{sel: 3'd5, exp: 5'b00000};
    range5[2] = '{sel: 3'd1, exp: 5'b00010};
    range5[3] = '{sel: 3'd6, exp: 5'b00000};
    range5[4] = '{sel: 3'd2, exp: 5'b00100};
    range5[5] = '{sel: 3'd7, exp: 5'b00000};
    range5[6] = '{sel: 3'd3, exp: 5'b01000};
    range5[7] = '{sel: 3'd4, exp: 5'b10000};

    rst_a = 1'b1;
    sel_a = 2'd3;
    rst_b = 1'b1;
    sel_b = 3'd4;

    // Reset held for two cycles with select=3: out stays zero.
    @(posedge clk); #1;
    inv_en = 1'b1;
    chk("reset_cycle1_a", 8'(out_a), 8'h00);
    chk("reset_cycle1_b", 8'(out_b), 8'h00);
    @(posedge clk); #1;
    chk("reset_cycle2_a", 8'(out_a), 8'h00);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk("reset_release_before_edge", 8'(out_a), 8'h00);
    @(posedge clk); #1;
    chk("reset_release_first_decode", 8'(out_a), 8'b1000);
    chk("reset_release_b_sel4", 8'(out_b), 8'b10000);

    // Sweep: each select held 100 cycles; out changes one edge later.
    prev = 4'b1000;
    for (int v = 0; v < 4; v++) begin
      sel_a = sweep[v].sel;
      @(negedge clk);
      chk("sweep_hold_old", 8'(out_a), 8'(prev));
      for (int c = 0; c < 100; c++) begin
        @(posedge clk); #1;
        chk("sweep_value", 8'(out_a), 8'(sweep[v].exp));
      end
      prev = sweep[v].exp;
    end

    // Latency: 1 -> 2 changed just after edge N.
    sel_a = 2'd1;
    @(posedge clk); #1;
    chk("latency_pre", 8'(out_a), 8'b0010);
    sel_a = 2'd2;
    @(negedge clk);
    chk("latency_hold", 8'(out_a), 8'b0010);
    @(posedge clk); #1;
    chk("latency_update", 8'(out_a), 8'b0100);

    // Mid-run reset pulse: no effect until the edge, then clears for one cycle.
    rst_a = 1'b1;
    @(negedge clk);
    chk("midrst_no_async", 8'(out_a), 8'b0100);
    @(posedge clk); #1;
    chk("midrst_cleared", 8'(out_a), 8'b0000);
    rst_a = 1'b0;
    @(posedge clk); #1;
    chk("midrst_recover", 8'(out_a), 8'b0100);

    // Five-output instance: in-range and out-of-range indices.
    for (int v = 0; v < 8; v++) begin
      sel_b = range5[v].sel;
      @(posedge clk); #1;
      chk("range5_decode", 8'(out_b), 8'(range5[v].exp));
    end

    // Stable out-of-range select keeps out at zero.
    sel_b = 3'd6;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("range5_stable_oor", 8'(out_b), 8'h00);
    end

    // Reset on the five-output instance overrides an in-range select.
    sel_b = 3'd4;
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("range5_reset", 8'(out_b), 8'h00);
    rst_b = 1'b0;
    @(posedge clk); #1;
    chk("range5_after_reset", 8'(out_b), 8'b10000);

    @(negedge clk);
    inv_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
